// File: rtl/wb2axi4l_timeout_bridge.sv
// Wishbone (pipelined slave) to AXI4-Lite (master) bridge, one transaction in flight,
// with a response-wait watchdog and a sticky timeout indication.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for wb_cyc & wb_stb; the only non-stalling state
// WRITE   | awvalid / wvalid held until their own handshakes complete
// WRESP   | bready held, waiting for bvalid
// READ    | arvalid held, waiting for arready
// RDATA   | rready held, waiting for rvalid
// DONE    | one-cycle wb_ack / wb_err pulse (suppressed if the master left)
module wb2axi4l_timeout_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic                    wb_cyc,
    input  logic                    wb_stb,
    input  logic                    wb_we,
    input  logic [ADDR_WIDTH-1:0]   wb_adr,
    input  logic [DATA_WIDTH/8-1:0] wb_sel,
    input  logic [DATA_WIDTH-1:0]   wb_wdat,
    output logic [DATA_WIDTH-1:0]   wb_rdat,
    output logic                    wb_ack,
    output logic                    wb_err,
    output logic                    wb_stall,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rvalid,
    output logic                    rready,
    output logic                    timeout_flag
);

    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_WRESP, S_READ, S_RDATA, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
    logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic                    abort_q, abort_d;
    logic                    tmo_flag_q, tmo_flag_d;
    logic [CNT_W-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic                    busy, quiet, tmo_hit;

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        sel_d      = sel_q;
        wdat_d     = wdat_q;
        rdat_d     = '0;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        abort_d    = abort_q;
        tmo_flag_d = tmo_flag_q;
        tmo_cnt_d  = tmo_cnt_q;

        busy    = (state_q == S_WRITE) || (state_q == S_WRESP) ||
                  (state_q == S_READ)  || (state_q == S_RDATA);
        // Once the master drops wb_cyc the response is swallowed, but AXI still completes.
        quiet   = abort_q || !wb_cyc;
        tmo_hit = (TIMEOUT_CYCLES != 0) && busy && (tmo_cnt_q == CNT_W'(1));

        if (busy) begin
            abort_d = quiet;
            if (TIMEOUT_CYCLES != 0) tmo_cnt_d = tmo_cnt_q - CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (wb_cyc && wb_stb) begin
                    adr_d     = wb_adr;
                    sel_d     = wb_sel;
                    wdat_d    = wb_wdat;
                    abort_d   = 1'b0;
                    tmo_cnt_d = CNT_W'(TIMEOUT_CYCLES);
                    if (wb_we) begin
                        state_d   = S_WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_READ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                awvalid_d = awvalid_q && !awready;
                wvalid_d  = wvalid_q && !wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = S_WRESP;
                    bready_d = 1'b1;
                end
            end
            S_WRESP: begin
                if (bvalid) begin
                    state_d  = S_DONE;
                    bready_d = 1'b0;
                    ack_d    = !quiet && !bresp[1];
                    err_d    = !quiet && bresp[1];
                end
            end
            S_READ: begin
                if (arready) begin
                    state_d   = S_RDATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            S_RDATA: begin
                if (rvalid) begin
                    state_d  = S_DONE;
                    rready_d = 1'b0;
                    ack_d    = !quiet && !rresp[1];
                    err_d    = !quiet && rresp[1];
                    rdat_d   = (!quiet && !rresp[1]) ? rdata : '0;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (tmo_hit) begin
            state_d    = S_DONE;
            awvalid_d  = 1'b0;
            wvalid_d   = 1'b0;
            bready_d   = 1'b0;
            arvalid_d  = 1'b0;
            rready_d   = 1'b0;
            ack_d      = 1'b0;
            err_d      = !quiet;
            rdat_d     = '0;
            tmo_flag_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q    <= S_IDLE;
            adr_q      <= '0;
            sel_q      <= '0;
            wdat_q     <= '0;
            rdat_q     <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            abort_q    <= 1'b0;
            tmo_flag_q <= 1'b0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            sel_q      <= sel_d;
            wdat_q     <= wdat_d;
            rdat_q     <= rdat_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            abort_q    <= abort_d;
            tmo_flag_q <= tmo_flag_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    assign wb_stall     = !RSTN || (state_q != S_IDLE);
    assign wb_ack       = ack_q;
    assign wb_err       = err_q;
    assign wb_rdat      = rdat_q;
    assign awaddr       = adr_q;
    assign araddr       = adr_q;
    assign wdata        = wdat_q;
    assign wstrb        = sel_q;
    assign awvalid      = awvalid_q;
    assign wvalid       = wvalid_q;
    assign bready       = bready_q;
    assign arvalid      = arvalid_q;
    assign rready       = rready_q;
    assign timeout_flag = tmo_flag_q;

endmodule

// File: tb/tb_wb2axi4l_timeout_bridge.sv
// Scoreboard bench: stimulus pushes expected WB responses and AXI beats into arrays,
// a negedge slave/monitor process consumes and compares them.
module tb_wb2axi4l_timeout_bridge;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr, wb_wdat, wb_rdat;
    logic [3:0]  wb_sel;
    logic        wb_ack, wb_err, wb_stall;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, timeout_flag;
    logic [1:0]  bresp, rresp;

    wb2axi4l_timeout_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_sel(wb_sel), .wb_wdat(wb_wdat), .wb_rdat(wb_rdat),
        .wb_ack(wb_ack), .wb_err(wb_err), .wb_stall(wb_stall),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .timeout_flag(timeout_flag)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expectation arrays: written by stimulus only, consumed by index in the monitor.
    logic        sb_err  [64];
    logic [31:0] sb_rdat [64];
    logic [31:0] ex_aw   [64];
    logic [31:0] ex_wd   [64];
    logic [3:0]  ex_ws   [64];
    int n_sb_push = 0, n_sb_pop = 0;
    int n_aw_push = 0, n_aw_pop = 0, n_w_pop = 0;

    // Slave configuration, owned by stimulus.
    int          aw_dly = 0, w_dly = 0, ar_dly = 0;
    logic        never_b = 1'b0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic        r_force = 1'b0;
    logic [31:0] r_force_val = 32'h0;
    int          clr_req = 0;

    // Slave state, owned by the slave process.
    logic [31:0] smem [logic [31:0]];
    int          aw_cnt, w_cnt, ar_cnt, clr_seen;
    logic        pend_aw, pend_w, pend_b, pend_r;
    logic [31:0] cur_aw, cur_w, r_addr;

    initial begin
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; clr_seen = 0;
        pend_aw = 0; pend_w = 0; pend_b = 0; pend_r = 0;
        cur_aw = 0; cur_w = 0; r_addr = 0;
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = 0;
        forever begin
            @(negedge CLK);
            if (clr_req != clr_seen) begin
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
                pend_aw = 0; pend_w = 0; pend_b = 0; pend_r = 0;
                clr_seen = clr_req;
            end
            awready = (aw_cnt >= aw_dly);
            wready  = (w_cnt >= w_dly);
            arready = (ar_cnt >= ar_dly);
            bvalid  = pend_b && !never_b;
            bresp   = bresp_cfg;
            rvalid  = pend_r;
            rresp   = rresp_cfg;
            rdata   = r_force ? r_force_val : (smem.exists(r_addr) ? smem[r_addr] : 32'h0);

            if (awvalid) begin
                if (awready) begin
                    if (n_aw_pop >= n_aw_push) chk("aw_unexpected", 1, 0);
                    else chk("aw_addr", awaddr, ex_aw[n_aw_pop]);
                    n_aw_pop++;
                    cur_aw = awaddr; pend_aw = 1; aw_cnt = 0;
                end else aw_cnt++;
            end
            if (wvalid) begin
                if (wready) begin
                    if (n_w_pop >= n_aw_push) chk("w_unexpected", 1, 0);
                    else begin
                        chk("w_data", wdata, ex_wd[n_w_pop]);
                        chk("w_strb", wstrb, ex_ws[n_w_pop]);
                    end
                    n_w_pop++;
                    cur_w = wdata; pend_w = 1; w_cnt = 0;
                end else w_cnt++;
            end
            if (bvalid && bready) pend_b = 0;
            if (pend_aw && pend_w) begin
                smem[cur_aw] = cur_w;
                pend_aw = 0; pend_w = 0; pend_b = 1;
            end
            if (rvalid && rready) pend_r = 0;
            if (arvalid) begin
                if (arready) begin
                    r_addr = araddr; pend_r = 1; ar_cnt = 0;
                end else ar_cnt++;
            end

            if (wb_ack || wb_err) begin
                if (n_sb_pop >= n_sb_push) chk("resp_unexpected", {wb_ack, wb_err}, 0);
                else begin
                    chk("resp_err",  wb_err,  sb_err[n_sb_pop]);
                    chk("resp_ack",  wb_ack,  !sb_err[n_sb_pop]);
                    chk("resp_rdat", wb_rdat, sb_rdat[n_sb_pop]);
                end
                n_sb_pop++;
            end
            if (!wb_ack) chk("rdat_idle_zero", wb_rdat, 0);
        end
    end

    logic [31:0] ref_mem [logic [31:0]];

    // exp_k: posedges from the accept edge to the response becoming visible (-1: don't care).
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic exp_err, input logic [31:0] exp_rdat,
                        input int exp_k, input bit drop);
        int  it;
        bit  done;
        @(negedge CLK);
        chk("stall_before_accept", wb_stall, 0);
        wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_wdat = dat; wb_sel = 4'hF;
        if (we) begin
            ex_aw[n_aw_push] = adr; ex_wd[n_aw_push] = dat; ex_ws[n_aw_push] = 4'hF;
            n_aw_push++;
        end
        if (!drop) begin
            sb_err[n_sb_push] = exp_err; sb_rdat[n_sb_push] = exp_rdat;
            n_sb_push++;
        end
        @(posedge CLK);
        #1 wb_stb = 0;
        if (drop) begin
            @(negedge CLK);
            wb_cyc = 0;
            repeat (12) @(negedge CLK);
            chk("stall_after_abort", wb_stall, 0);
            return;
        end
        done = 0;
        it = 0;
        while (!done && it < 40) begin
            @(negedge CLK);
            it++;
            chk("stall_busy", wb_stall, 1);
            if (wb_ack || wb_err) done = 1;
        end
        if (!done) chk("response_timeout", 0, 1);
        else if (exp_k >= 0) chk("latency", it - 1, exp_k);
        wb_cyc = 0;
        @(negedge CLK);
        chk("stall_back_idle", wb_stall, 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_stall", wb_stall, 1);
        chk("rst_ack_err", {wb_ack, wb_err}, 0);
        chk("rst_rdat", wb_rdat, 0);
        chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
        chk("rst_addr", {awaddr, araddr}, 0);
        chk("rst_wdata", {wstrb, wdata}, 0);
        chk("rst_tmo_flag", timeout_flag, 0);
    endtask

    initial begin
        logic [31:0] d;
        RSTN = 0; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = 0; wb_wdat = 0; wb_sel = 0;
        repeat (3) @(negedge CLK);
        chk_reset_outputs();
        RSTN = 1;
        @(negedge CLK);
        chk("idle_stall", wb_stall, 0);

        // Write with awready held off 3 cycles, wready immediate.
        aw_dly = 3;
        xfer(1, 32'h10, 32'hDEADBEEF, 0, 0, -1, 0);
        ref_mem[32'h10] = 32'hDEADBEEF;
        aw_dly = 0;

        // Read with forced slave data; zero-wait slave gives response 2 edges after accept.
        r_force = 1; r_force_val = 32'h12345678;
        xfer(0, 32'h10, 0, 0, 32'h12345678, 2, 0);
        r_force = 0;
        xfer(1, 32'h14, 32'hCAFEF00D, 0, 0, 2, 0);
        ref_mem[32'h14] = 32'hCAFEF00D;

        // Error responses: SLVERR write, DECERR read.
        bresp_cfg = 2'b10;
        xfer(1, 32'h80, 32'h11112222, 1, 0, -1, 0);
        bresp_cfg = 2'b00;
        rresp_cfg = 2'b11;
        xfer(0, 32'h10, 0, 1, 0, -1, 0);
        rresp_cfg = 2'b00;
        chk("no_tmo_yet", timeout_flag, 0);

        // Slave never answers the write: watchdog fires 16 cycles after entering WRITE.
        never_b = 1;
        xfer(1, 32'h84, 32'h55667788, 1, 0, 16, 0);
        chk("tmo_flag_set", timeout_flag, 1);
        clr_req++;
        never_b = 0;
        xfer(0, 32'h10, 0, 0, ref_mem[32'h10], -1, 0);
        chk("tmo_flag_sticky", timeout_flag, 1);

        // Master abandons a write one cycle after accept: AXI completes, no WB response.
        xfer(1, 32'h88, 32'hA5A5C3C3, 0, 0, -1, 1);
        ref_mem[32'h88] = 32'hA5A5C3C3;
        xfer(0, 32'h88, 0, 0, ref_mem[32'h88], -1, 0);

        // Reset during a pending read whose arready never comes in time.
        ar_dly = 10;
        @(negedge CLK);
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h14;
        @(posedge CLK);
        #1 wb_stb = 0;
        repeat (3) @(negedge CLK);
        RSTN = 0;
        clr_req++;
        repeat (2) @(negedge CLK);
        chk_reset_outputs();
        RSTN = 1; wb_cyc = 0; ar_dly = 0;
        @(negedge CLK);
        chk("idle_after_reset", wb_stall, 0);

        // Back-to-back write/read pairs with random data and random ready delays.
        for (int i = 0; i < 16; i++) begin
            aw_dly = $urandom_range(0, 3);
            w_dly  = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3);
            d = $urandom;
            xfer(1, 32'(i * 4), d, 0, 0, -1, 0);
            ref_mem[32'(i * 4)] = d;
            xfer(0, 32'(i * 4), 0, 0, ref_mem[32'(i * 4)], -1, 0);
        end

        repeat (5) @(negedge CLK);
        chk("all_responses_seen", n_sb_pop, n_sb_push);
        chk("all_aw_seen", n_aw_pop, n_aw_push);
        chk("all_w_seen", n_w_pop, n_aw_push);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/wb2axi4l_timeout_bridge.md
WB2AXI4L_TIMEOUT_BRIDGE -- requirements
Module: wb2axi4l_timeout_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning address width of both ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data width in bits; legal values are 32 and 64.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning AXI response wait limit in cycles; 0 disables the timeout.
REQ-004 SHALL have port CLK, input, 1, meaning the single clock; all logic is synchronous to its rising edge.
REQ-005 SHALL have port RSTN, input, 1, meaning synchronous active-low reset.
REQ-006 SHALL have Wishbone slave ports: wb_cyc, wb_stb and wb_we (in, 1 each); wb_adr (in, ADDR_WIDTH); wb_sel (in, DATA_WIDTH/8); wb_wdat (in, DATA_WIDTH); wb_rdat (out, DATA_WIDTH); wb_ack, wb_err and wb_stall (out, 1 each).
REQ-007 SHALL have AXI4-Lite master ports: awaddr/araddr (out, ADDR_WIDTH); awvalid, wvalid, bready, arvalid and rready (out, 1 each); awready, wready, bvalid, arready and rvalid (in, 1 each); wdata (out, DATA_WIDTH); wstrb (out, DATA_WIDTH/8); bresp and rresp (in, 2 each); rdata (in, DATA_WIDTH).
REQ-008 SHALL have output timeout_flag, 1, sticky indication that a timeout occurred; cleared only by reset.

Function
REQ-009 SHALL implement FSM states IDLE, WRITE, WRESP, READ, RDATA and DONE.
REQ-010 SHALL drive wb_stall=0 in IDLE only and wb_stall=1 in all other states; one transaction is outstanding at a time.
REQ-011 In IDLE with wb_cyc&wb_stb=1, SHALL register adr, sel and wdat in the same cycle, then go to WRITE if wb_we=1, else READ.
REQ-012 In WRITE, SHALL assert awvalid and wvalid with awaddr=adr, wdata=wdat and wstrb=sel.
REQ-013 In WRITE, SHALL drop each valid independently on its own ready and go to WRESP once both handshakes are complete, in either order or simultaneously.
REQ-014 In WRESP, SHALL hold bready=1 and capture bresp on bvalid.
REQ-015 In READ, SHALL assert arvalid with araddr=adr and go to RDATA on arready.
REQ-016 In RDATA, SHALL hold rready=1 and capture rdata and rresp on rvalid.
REQ-017 No AXI valid SHALL depend combinationally on any AXI ready; valids SHALL be registered and held until their handshake.
REQ-018 On entering DONE, SHALL pulse exactly one of wb_ack (resp=OKAY or EXOKAY) or wb_err (resp=SLVERR or DECERR) for one cycle, then return to IDLE.
REQ-019 During a read, wb_rdat SHALL equal captured rdata while wb_ack=1; wb_rdat SHALL be 0 on error and after a write.
REQ-020 SHALL count cycles spent in WRITE/WRESP/READ/RDATA; on reaching TIMEOUT_CYCLES (when nonzero), SHALL go to DONE, pulse wb_err, set timeout_flag, and deassert all AXI valids/readies.
REQ-021 If wb_cyc falls while the FSM is not in IDLE, SHALL complete the AXI handshakes and suppress the wb_ack/wb_err pulse.
REQ-022 After a timeout, a late bvalid or rvalid SHALL be ignored (no ack, no state change) until the next transaction.
REQ-023 Latency SHALL be 3 cycles from stb accepted to ack when all AXI readies/valids respond in 0 cycles: accept, address/data handshake, response capture with ack.

Reset
REQ-024 With RSTN=0 at a CLK edge, SHALL enter IDLE and clear wb_ack, wb_err and wb_rdat, all AXI valids/readies, the timeout counter, and timeout_flag.
REQ-025 With RSTN=0, wb_stall SHALL be 1 and all address/data/strobe outputs SHALL be 0.
REQ-026 Reset asserted mid-transaction SHALL abort it with no Wishbone response; the AXI handshake is not completed.

Verification
REQ-027 Write adr=0x10, wdat=0xDEADBEEF, sel=0xF, with awready delayed 3 cycles and wready immediate -> one AW and one W handshake with matching values, wstrb=0xF, one wb_ack.
REQ-028 Read adr=0x10, slave returns rdata=0x12345678 with rresp=OKAY -> wb_ack with wb_rdat=0x12345678; wb_err stays 0.
REQ-029 Write with slave bresp=SLVERR, then read with rresp=DECERR -> a wb_err pulse for each, no wb_ack, wb_rdat=0.
REQ-030 TIMEOUT_CYCLES=16 with a slave that never asserts bvalid -> wb_err exactly 16 cycles after entering WRITE, timeout_flag=1, and a subsequent normal read succeeds.
REQ-031 Drop wb_cyc 1 cycle after accept, then issue reset during a pending read -> no Wishbone response in either case, outputs at reset values, FSM in IDLE.
REQ-032 Sixteen back-to-back write/read pairs at addresses 0x00-0x3C with random data -> every read returns its paired write data; wb_stall=1 whenever the FSM is not in IDLE.
